// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the write-back path.
//   WB_SEL_*    : write-back source select codes (channel index into in_src)
//   wb_entry_t  : one buffered write-back transaction {data, dst, sel_err}
//                 sized for the default 32-bit datapath / 32-entry register file
package cpu_pkg;

  localparam int WB_WIDTH  = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_SEL_W  = 4;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU    = 4'd0;
  localparam logic [WB_SEL_W-1:0] WB_SEL_HI     = 4'd1;
  localparam logic [WB_SEL_W-1:0] WB_SEL_LO     = 4'd2;
  localparam logic [WB_SEL_W-1:0] WB_SEL_MDR    = 4'd3;
  localparam logic [WB_SEL_W-1:0] WB_SEL_CONST  = 4'd4;
  localparam logic [WB_SEL_W-1:0] WB_SEL_REGDES = 4'd5;
  localparam logic [WB_SEL_W-1:0] WB_SEL_LT     = 4'd6;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC     = 4'd7;
  localparam logic [WB_SEL_W-1:0] WB_SEL_SL16   = 4'd8;

  typedef struct packed {
    logic [WB_WIDTH-1:0]  data;
    logic [WB_ADDR_W-1:0] dst;
    logic                 sel_err;
  } wb_entry_t;

endpackage

// File: rtl/wb_select_pipe_if.sv
// Write-back selector bus: upstream transaction channel (in_*) and the
// register-file side channel (out_*), plus buffer occupancy.
//   master : driven by the datapath / register file (offers in_*, drives out_ready)
//   slave  : the wb_select_pipe block
interface wb_select_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int N_SRC  = 9,
  parameter int SEL_W  = 4,
  parameter int ADDR_W = 5
);

  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic [N_SRC*WIDTH-1:0] in_src;
  logic [ADDR_W-1:0]      in_dst;

  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [ADDR_W-1:0]      out_dst;
  logic                   out_sel_err;
  logic [1:0]             occupancy;

  modport master (
    output in_valid, in_sel, in_src, in_dst, out_ready,
    input  in_ready, out_valid, out_data, out_dst, out_sel_err, occupancy
  );

  modport slave (
    input  in_valid, in_sel, in_src, in_dst, out_ready,
    output in_ready, out_valid, out_data, out_dst, out_sel_err, occupancy
  );

endinterface

// File: rtl/wb_skid_fifo2.sv
// Generic 2-entry in-order buffer with valid/ready on both sides.
//   clk, reset_n   : clock, asynchronous active-low reset
//   push_valid/ready/data : write side; push_ready depends on state only
//   pop_valid/ready/data  : read side; pop_data is the registered head
//   occupancy      : entries held, 0..2
// The head register drives pop_data directly, so there is no combinational
// path from the write side to the read side.
module wb_skid_fifo2
  import cpu_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_valid,
  output logic       push_ready,
  input  entry_t     push_data,
  output logic       pop_valid,
  input  logic       pop_ready,
  output entry_t     pop_data,
  output logic [1:0] occupancy
);

  // Encoding equals the entry count so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  fifo_state_e state, state_next;
  entry_t      head, head_next;
  entry_t      tail, tail_next;
  logic        push, pop;

  assign push_ready = (state != FULL);
  assign pop_valid  = (state != EMPTY);
  assign push       = push_valid && push_ready;
  assign pop        = pop_ready && pop_valid;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    unique case (state)
      EMPTY: begin
        if (push) begin
          head_next  = push_data;
          state_next = ONE;
        end
      end
      ONE: begin
        unique case ({push, pop})
          2'b10: begin
            tail_next  = push_data;
            state_next = FULL;
          end
          2'b01: state_next = EMPTY;  // head keeps its last value
          2'b11: head_next  = push_data;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_next  = tail;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      // NOTE: both storage entries are reset: the head is visible on the
      // output and must read zero out of reset, and clearing the tail too
      // keeps unknowns out of the head when it is promoted.
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

  assign pop_data  = head;
  assign occupancy = state;

endmodule

// File: rtl/wb_select_pipe.sv
// Register-file write-back source selector with a 2-entry output buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_sel/in_src/in_dst upstream,
//                  out_valid/out_ready/out_data/out_dst/out_sel_err downstream,
//                  occupancy (0..2)
// The selected source word is paired with its destination address and
// buffered; an out-of-range select substitutes CONST_VAL and flags sel_err.
// With ZERO_DROP set, writes to register 0 complete the handshake but are
// discarded instead of being buffered.
module wb_select_pipe
  import cpu_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          N_SRC     = 9,
  parameter int          SEL_W     = 4,
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] CONST_VAL = 32'h227,
  parameter bit          ZERO_DROP = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  wb_select_pipe_if.slave bus
);

  if ((2 ** SEL_W) < N_SRC) begin : g_bad_params
    $error("wb_select_pipe: SEL_W=%0d cannot encode N_SRC=%0d sources", SEL_W, N_SRC);
  end

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] dst;
    logic              sel_err;
  } entry_t;

  localparam logic [WIDTH-1:0] CONST_WORD = WIDTH'(CONST_VAL);

  entry_t sel_entry;
  entry_t head;
  logic   drop;
  logic   push_ready;
  logic   pop_valid;

  // Start from the out-of-range result and let a matching channel override it.
  always_comb begin
    sel_entry.data    = CONST_WORD;
    sel_entry.sel_err = 1'b1;
    sel_entry.dst     = bus.in_dst;
    for (int k = 0; k < N_SRC; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_entry.data    = bus.in_src[k*WIDTH +: WIDTH];
        sel_entry.sel_err = 1'b0;
      end
    end
  end

  // A dropped write still sees in_ready, so upstream completes its handshake.
  assign drop = ZERO_DROP && (bus.in_dst == '0);

  wb_skid_fifo2 #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (bus.in_valid && !drop),
    .push_ready (push_ready),
    .push_data  (sel_entry),
    .pop_valid  (pop_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (head),
    .occupancy  (bus.occupancy)
  );

  assign bus.in_ready    = push_ready;
  assign bus.out_valid   = pop_valid;
  assign bus.out_data    = head.data;
  assign bus.out_dst     = head.dst;
  assign bus.out_sel_err = head.sel_err;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Self-checking bench for wb_select_pipe: table-driven vectors through a
// scoreboard plus hand-written backpressure, drop, push/pop and reset cases.
module tb_wb_select_pipe;
  import cpu_pkg::*;

  localparam int WIDTH  = 32;
  localparam int N_SRC  = 9;
  localparam int SEL_W  = 4;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_select_pipe_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W)) bus ();
  wb_select_pipe_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W)) bus_nd ();

  logic [N_SRC*WIDTH-1:0] src_bus;
  assign bus.in_src    = src_bus;
  assign bus_nd.in_src = src_bus;

  wb_select_pipe #(
    .WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
    .CONST_VAL(32'h227), .ZERO_DROP(1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  wb_select_pipe #(
    .WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
    .CONST_VAL(32'h227), .ZERO_DROP(1'b0)
  ) dut_nd (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_nd.slave)
  );

  typedef struct {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] dst;
    logic              err;
  } exp_t;

  typedef struct {
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] dst;
    logic [WIDTH-1:0]  data;
    logic              err;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[11];
  int   tests = 0;
  int   fails = 0;
  logic acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then step to just after the edge.
  task automatic tick(output logic accepted);
    exp_t e;
    @(negedge clk);
    accepted = bus.in_valid && bus.in_ready;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got data %h dst %0d, expected no output", bus.out_data, bus.out_dst);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", bus.out_data, e.data);
        check("sb_dst", 32'(bus.out_dst), 32'(e.dst));
        check("sb_err", 32'(bus.out_sel_err), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  // Offer one transaction until accepted; queue its expectation unless dropped.
  task automatic send(input logic [SEL_W-1:0] sel, input logic [ADDR_W-1:0] dst,
                      input logic [WIDTH-1:0] data, input logic err, input logic dropped);
    logic a;
    int   n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_dst   = dst;
    n = 0;
    do begin
      tick(a);
      n++;
    end while (!a && n < 50);
    bus.in_valid = 1'b0;
    if (!a) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept for sel %0d dst %0d, expected accept", sel, dst);
    end else if (!dropped) begin
      e.data = data;
      e.dst  = dst;
      e.err  = err;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N_SRC; k++) src_bus[k*WIDTH +: WIDTH] = 32'hA000_0000 | 32'(k);
    src_bus[WB_SEL_ALU*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    src_bus[WB_SEL_MDR*WIDTH +: WIDTH] = 32'h0000_1234;
    src_bus[WB_SEL_PC*WIDTH +: WIDTH]  = 32'h0000_0400;

    vecs[0]  = '{WB_SEL_ALU,    5'd1,  32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{WB_SEL_HI,     5'd2,  32'hA000_0001, 1'b0};
    vecs[2]  = '{WB_SEL_LO,     5'd3,  32'hA000_0002, 1'b0};
    vecs[3]  = '{WB_SEL_CONST,  5'd4,  32'hA000_0004, 1'b0};
    vecs[4]  = '{WB_SEL_REGDES, 5'd5,  32'hA000_0005, 1'b0};
    vecs[5]  = '{WB_SEL_LT,     5'd6,  32'hA000_0006, 1'b0};
    vecs[6]  = '{WB_SEL_PC,     5'd7,  32'h0000_0400, 1'b0};
    vecs[7]  = '{WB_SEL_SL16,   5'd31, 32'hA000_0008, 1'b0};
    vecs[8]  = '{4'd9,          5'd17, 32'h0000_0227, 1'b1};
    vecs[9]  = '{4'd15,         5'd30, 32'h0000_0227, 1'b1};
    vecs[10] = '{WB_SEL_MDR,    5'd16, 32'h0000_1234, 1'b0};

    bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_dst = '0; bus.out_ready = 1'b0;
    bus_nd.in_valid = 1'b0; bus_nd.in_sel = '0; bus_nd.in_dst = '0; bus_nd.out_ready = 1'b0;

    // Reset state
    reset_n = 1'b0;
    #12;
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_dst", 32'(bus.out_dst), 32'd0);
    check("rst_sel_err", 32'(bus.out_sel_err), 32'd0);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Single transaction, one-cycle latency, data retained after drain
    bus.out_ready = 1'b1;
    send(WB_SEL_ALU, 5'd8, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("single_out_valid", 32'(bus.out_valid), 32'd1);
    check("single_out_data", bus.out_data, 32'hDEAD_BEEF);
    check("single_out_dst", 32'(bus.out_dst), 32'd8);
    check("single_sel_err", 32'(bus.out_sel_err), 32'd0);
    idle(1);
    check("single_drained_occ", 32'(bus.occupancy), 32'd0);
    check("single_drained_valid", 32'(bus.out_valid), 32'd0);
    check("single_retained_data", bus.out_data, 32'hDEAD_BEEF);

    // Table-driven stream with out_ready high (simultaneous push/pop at occ=1)
    for (int i = 0; i < 11; i++) send(vecs[i].sel, vecs[i].dst, vecs[i].data, vecs[i].err, 1'b0);
    idle(3);
    check("table_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: fill, hold the head, then drain in order
    bus.out_ready = 1'b0;
    send(WB_SEL_MDR, 5'd9, 32'h0000_1234, 1'b0, 1'b0);
    send(WB_SEL_PC, 5'd10, 32'h0000_0400, 1'b0, 1'b0);
    check("bp_occupancy", 32'(bus.occupancy), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_head_data", bus.out_data, 32'h0000_1234);
      check("bp_head_dst", 32'(bus.out_dst), 32'd9);
      idle(1);
    end
    bus.out_ready = 1'b1;
    idle(3);
    check("bp_drained_occ", 32'(bus.occupancy), 32'd0);
    check("bp_drained_q", 32'(exp_q.size()), 32'd0);

    // Out-of-range select
    bus.out_ready = 1'b0;
    send(4'd12, 5'd3, 32'h0000_0227, 1'b1, 1'b0);
    check("oor_data", bus.out_data, 32'h0000_0227);
    check("oor_err", 32'(bus.out_sel_err), 32'd1);
    bus.out_ready = 1'b1;
    idle(2);

    // Zero drop: handshake completes, nothing enqueued
    bus.out_ready = 1'b0;
    send(WB_SEL_LO, 5'd0, 32'hA000_0002, 1'b0, 1'b1);
    check("drop_occupancy", 32'(bus.occupancy), 32'd0);
    check("drop_out_valid", 32'(bus.out_valid), 32'd0);
    idle(1);
    check("drop_out_valid_later", 32'(bus.out_valid), 32'd0);

    // Same stimulus on the ZERO_DROP=0 instance is enqueued
    bus_nd.in_valid = 1'b1;
    bus_nd.in_sel   = WB_SEL_LO;
    bus_nd.in_dst   = 5'd0;
    @(negedge clk);
    check("nd_in_ready", 32'(bus_nd.in_ready), 32'd1);
    @(posedge clk); #1;
    bus_nd.in_valid = 1'b0;
    check("nd_occupancy", 32'(bus_nd.occupancy), 32'd1);
    check("nd_out_valid", 32'(bus_nd.out_valid), 32'd1);
    check("nd_out_data", bus_nd.out_data, 32'hA000_0002);
    check("nd_out_dst", 32'(bus_nd.out_dst), 32'd0);

    // Drop coinciding with a pop: occupancy still decrements
    send(WB_SEL_HI, 5'd5, 32'hA000_0001, 1'b0, 1'b0);
    check("dpop_occ_before", 32'(bus.occupancy), 32'd1);
    bus.out_ready = 1'b1;
    send(WB_SEL_LO, 5'd0, 32'hA000_0002, 1'b0, 1'b1);
    check("dpop_occ_after", 32'(bus.occupancy), 32'd0);

    // Simultaneous push and pop at occupancy 1
    bus.out_ready = 1'b0;
    send(WB_SEL_CONST, 5'd11, 32'hA000_0004, 1'b0, 1'b0);
    check("pp_occ_before", 32'(bus.occupancy), 32'd1);
    bus.out_ready = 1'b1;
    send(WB_SEL_REGDES, 5'd12, 32'hA000_0005, 1'b0, 1'b0);
    check("pp_occ_after", 32'(bus.occupancy), 32'd1);
    check("pp_head_data", bus.out_data, 32'hA000_0005);
    check("pp_head_dst", 32'(bus.out_dst), 32'd12);
    idle(2);
    check("pp_drained_q", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with the buffer full
    bus.out_ready = 1'b0;
    send(WB_SEL_HI, 5'd20, 32'hA000_0001, 1'b0, 1'b0);
    send(WB_SEL_LO, 5'd21, 32'hA000_0002, 1'b0, 1'b0);
    check("ar_occ_full", 32'(bus.occupancy), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check("ar_occupancy", 32'(bus.occupancy), 32'd0);
    exp_q.delete();
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("ar_in_ready", 32'(bus.in_ready), 32'd1);
    check("ar_occ_after", 32'(bus.occupancy), 32'd0);
    check("ar_out_data", bus.out_data, 32'd0);
    bus.out_ready = 1'b1;
    idle(2);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
